write_burst_scheduler: RTL and testbench



---
 rtl/write_burst_scheduler_pkg.sv | 36 +++
 rtl/write_burst_scheduler_if.sv | 62 ++++++
 rtl/write_burst_scheduler_splitter.sv | 63 ++++++
 rtl/write_burst_scheduler.sv | 124 ++++++++++++
 tb/tb_write_burst_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/write_burst_scheduler_pkg.sv
// Shared state encoding, page constants and the burst-sizing helper used by
// the write burst scheduler and its splitter.
package write_burst_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned PageBytes       = 4096;
    localparam int unsigned PageOffsetWidth = 12;

    // Next burst size: the smallest of the beats still owed, the burst cap and
    // the beats left before the next 4 KiB page boundary.
    function automatic logic [31:0] calc_burst_beats(
        input logic [PageOffsetWidth-1:0] page_offset,
        input logic [63:0]                remaining,
        input int unsigned                max_beats,
        input int unsigned                beat_bytes_log
    );
        logic [31:0] boundary_beats;
        logic [31:0] n;
        boundary_beats = (32'(PageBytes) - 32'(page_offset)) >> beat_bytes_log;
        n = 32'(max_beats);
        if (boundary_beats < n) begin
            n = boundary_beats;
        end
        if (remaining < 64'(n)) begin
            n = remaining[31:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/write_burst_scheduler_if.sv
// FIFO-style handshake bundle between the write burst scheduler and the
// request, AW, burst-length, response and completion FIFOs.
interface write_burst_scheduler_if #(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned ReqBeatsWidth = 32,
    parameter int unsigned BurstLenWidth = 8
);

    logic [AddrWidth+ReqBeatsWidth-1:0] req_dout;
    logic                               req_empty_n;
    logic                               req_read;

    logic [AddrWidth+BurstLenWidth-1:0] aw_din;
    logic                               aw_full_n;
    logic                               aw_write;

    logic [BurstLenWidth-1:0]           burst_len_din;
    logic                               burst_len_full_n;
    logic                               burst_len_write;

    logic                               resp_empty_n;
    logic                               resp_read;

    logic                               done_din;
    logic                               done_full_n;
    logic                               done_write;

    modport master (
        input  req_dout,
        input  req_empty_n,
        output req_read,
        output aw_din,
        input  aw_full_n,
        output aw_write,
        output burst_len_din,
        input  burst_len_full_n,
        output burst_len_write,
        input  resp_empty_n,
        output resp_read,
        output done_din,
        input  done_full_n,
        output done_write
    );

    modport slave (
        output req_dout,
        output req_empty_n,
        input  req_read,
        input  aw_din,
        output aw_full_n,
        input  aw_write,
        input  burst_len_din,
        output burst_len_full_n,
        input  burst_len_write,
        output resp_empty_n,
        input  resp_read,
        input  done_din,
        output done_full_n,
        input  done_write
    );

endinterface

// File: rtl/write_burst_scheduler_splitter.sv
// Holds the current burst address and beats still owed for one request, and
// sizes the next burst so it never crosses a 4 KiB page.
module burst_splitter
    import write_burst_pkg::*;
#(
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned BeatBytesLog  = 6,
    parameter int unsigned ReqBeatsWidth = 32,
    parameter int unsigned MaxBurstBeats = 16,
    parameter int unsigned BeatsWidth    = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [AddrWidth-1:0]     load_addr,
    input  logic [ReqBeatsWidth-1:0] load_beats,
    input  logic                     advance,
    output logic [AddrWidth-1:0]     addr,
    output logic [BeatsWidth-1:0]    burst_beats,
    output logic                     remaining_zero
);

    logic [AddrWidth-1:0]     addr_q;
    logic [AddrWidth-1:0]     addr_d;
    logic [ReqBeatsWidth-1:0] remaining_q;
    logic [ReqBeatsWidth-1:0] remaining_d;
    logic [31:0]              n_full;
    logic [AddrWidth-1:0]     next_addr;

    always_comb begin
        n_full    = calc_burst_beats(addr_q[PageOffsetWidth-1:0], 64'(remaining_q),
                                     MaxBurstBeats, BeatBytesLog);
        next_addr = addr_q + (AddrWidth'(n_full) << BeatBytesLog);
    end

    // n never exceeds remaining, so the subtraction cannot wrap below zero.
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (load) begin
            addr_d      = load_addr;
            remaining_d = load_beats;
        end else if (advance) begin
            addr_d      = next_addr;
            remaining_d = remaining_q - ReqBeatsWidth'(n_full);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    assign addr           = addr_q;
    assign burst_beats    = BeatsWidth'(n_full);
    assign remaining_zero = (remaining_q == '0);

endmodule

// File: rtl/write_burst_scheduler.sv
// Splits long write requests into page-safe bursts, pushes AW and burst-length
// entries in lockstep, and emits one completion per fully acknowledged request.
module write_burst_scheduler
    import write_burst_pkg::*;
#(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned BeatBytesLog   = 6,
    parameter int unsigned BurstLenWidth  = 8,
    parameter int unsigned MaxBurstBeats  = 16,
    parameter int unsigned ReqBeatsWidth  = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input logic                     clk,
    input logic                     rst,
    write_burst_scheduler_if.master bus
);

    localparam int unsigned BeatsWidth = BurstLenWidth + 1;
    localparam int unsigned OutWidth   = $clog2(MaxOutstanding + 1);

    state_e                   state_q;
    state_e                   state_d;
    logic [OutWidth-1:0]      outstanding_q;
    logic [OutWidth-1:0]      outstanding_d;

    logic                     take_req;
    logic                     issue;
    logic                     pop;
    logic                     done_write;
    logic                     can_issue;

    logic [AddrWidth-1:0]     burst_addr;
    logic [BeatsWidth-1:0]    burst_beats;
    logic [BeatsWidth-1:0]    beats_m1;
    logic [BurstLenWidth-1:0] burst_len;
    logic                     remaining_zero;

    burst_splitter #(
        .AddrWidth     (AddrWidth),
        .BeatBytesLog  (BeatBytesLog),
        .ReqBeatsWidth (ReqBeatsWidth),
        .MaxBurstBeats (MaxBurstBeats),
        .BeatsWidth    (BeatsWidth)
    ) u_splitter (
        .clk            (clk),
        .rst            (rst),
        .load           (take_req),
        .load_addr      (bus.req_dout[AddrWidth+ReqBeatsWidth-1:ReqBeatsWidth]),
        .load_beats     (bus.req_dout[ReqBeatsWidth-1:0]),
        .advance        (issue),
        .addr           (burst_addr),
        .burst_beats    (burst_beats),
        .remaining_zero (remaining_zero)
    );

    always_comb begin
        beats_m1  = burst_beats - BeatsWidth'(1);
        burst_len = beats_m1[BurstLenWidth-1:0];
        can_issue = bus.aw_full_n && bus.burst_len_full_n
                    && (outstanding_q < OutWidth'(MaxOutstanding));
        pop       = !rst && bus.resp_empty_n && (outstanding_q != '0);
    end

    // Every strobe is forced low during reset; AW and burst-length share one issue.
    always_comb begin
        state_d    = state_q;
        take_req   = 1'b0;
        issue      = 1'b0;
        done_write = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.req_empty_n) begin
                        take_req = 1'b1;
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    if (remaining_zero) begin
                        state_d = DRAIN;
                    end else if (can_issue) begin
                        issue = 1'b1;
                    end
                end
                DRAIN: begin
                    if (outstanding_q == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.done_full_n) begin
                        done_write = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + OutWidth'(issue) - OutWidth'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign bus.req_read        = take_req;
    assign bus.aw_din          = {burst_addr, burst_len};
    assign bus.aw_write        = issue;
    assign bus.burst_len_din   = burst_len;
    assign bus.burst_len_write = issue;
    assign bus.resp_read       = pop;
    assign bus.done_din        = 1'b1;
    assign bus.done_write      = done_write;

endmodule

// File: tb/tb_write_burst_scheduler.sv
// Directed bench for write_burst_scheduler: burst splitting, page boundaries,
// zero-beat requests, backpressure, mid-request reset and back-to-back requests.
module tb_write_burst_scheduler;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    write_burst_scheduler_if #(
        .AddrWidth     (64),
        .ReqBeatsWidth (32),
        .BurstLenWidth (8)
    ) bus ();

    write_burst_scheduler #(
        .AddrWidth      (64),
        .BeatBytesLog   (6),
        .BurstLenWidth  (8),
        .MaxBurstBeats  (16),
        .ReqBeatsWidth  (32),
        .MaxOutstanding (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge, then settle before sampling.
    task automatic applyStimulus(input logic rst_v, input logic req_e,
                                 input logic [63:0] addr, input logic [31:0] beats,
                                 input logic aw_f, input logic bl_f,
                                 input logic resp_e, input logic done_f);
        @(negedge clk);
        rst                  = rst_v;
        bus.req_empty_n      = req_e;
        bus.req_dout         = {addr, beats};
        bus.aw_full_n        = aw_f;
        bus.burst_len_full_n = bl_f;
        bus.resp_empty_n     = resp_e;
        bus.done_full_n      = done_f;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAw(input string tag, input logic [63:0] addr, input logic [7:0] len);
        checkOutput({tag, "_aw_write"}, 128'(bus.aw_write), 128'(1'b1));
        checkOutput({tag, "_bl_write"}, 128'(bus.burst_len_write), 128'(1'b1));
        checkOutput({tag, "_aw_din"}, 128'(bus.aw_din), 128'({addr, len}));
        checkOutput({tag, "_bl_din"}, 128'(bus.burst_len_din), 128'(len));
    endtask

    // Free-run with all flags open until done_write, counting bursts and pops.
    task automatic drainUntilDone(input string tag, input int exp_aws, input int exp_pops,
                                  input logic [71:0] exp_last_aw);
        int          aw_count;
        int          pop_count;
        logic        seen_done;
        logic [71:0] last_aw;
        aw_count  = 0;
        pop_count = 0;
        seen_done = 1'b0;
        last_aw   = '0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (bus.aw_write) begin
                aw_count++;
                last_aw = bus.aw_din;
            end
            if (bus.resp_read) pop_count++;
            if (bus.done_write) begin
                seen_done = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, 128'(seen_done), 128'(1'b1));
        checkOutput({tag, "_aw_count"}, 128'(aw_count), 128'(exp_aws));
        checkOutput({tag, "_pop_count"}, 128'(pop_count), 128'(exp_pops));
        checkOutput({tag, "_last_aw"}, 128'(last_aw), 128'(exp_last_aw));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput({tag, "_single_done"}, 128'(bus.done_write), 128'(1'b0));
    endtask

    initial begin
        // Reset: every strobe low even with all flags asserted.
        applyStimulus(1'b1, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_req_read", 128'(bus.req_read), 128'(1'b0));
        checkOutput("rst_aw_write", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("rst_bl_write", 128'(bus.burst_len_write), 128'(1'b0));
        checkOutput("rst_resp_read", 128'(bus.resp_read), 128'(1'b0));
        checkOutput("rst_done_write", 128'(bus.done_write), 128'(1'b0));

        // 40 beats from 0x0: 16 + 16 + 8 on consecutive cycles.
        $display("[TB] basic split");
        applyStimulus(1'b0, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t1_req_read", 128'(bus.req_read), 128'(1'b1));
        checkOutput("t1_no_aw_on_accept", 128'(bus.aw_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t1_b0", 64'h0, 8'd15);
        checkOutput("t1_req_read_busy", 128'(bus.req_read), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t1_b1", 64'h400, 8'd15);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t1_b2", 64'h800, 8'd7);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t1_no_fourth", 128'(bus.aw_write), 128'(1'b0));
        drainUntilDone("t1", 0, 3, 72'h0);

        // Page boundary: 0xFC0 has room for one beat before 0x1000.
        $display("[TB] page boundary");
        applyStimulus(1'b0, 1'b1, 64'hFC0, 32'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t2_req_read", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t2_b0", 64'hFC0, 8'd0);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t2_b1", 64'h1000, 8'd1);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t2_no_third", 128'(bus.aw_write), 128'(1'b0));
        drainUntilDone("t2", 0, 2, 72'h0);

        // Zero-beat request still yields exactly one completion.
        $display("[TB] zero beats");
        applyStimulus(1'b0, 1'b1, 64'h40, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t3_req_read", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t3_aw_write", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t3_bl_write", 128'(bus.burst_len_write), 128'(1'b0));
        drainUntilDone("t3", 0, 0, 72'h0);

        // Backpressure: 200 beats = 12 full bursts + one 8-beat burst.
        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b1, 64'h0, 32'd200, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_req_read", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_blfull_aw", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t4_blfull_bl", 128'(bus.burst_len_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_awfull_aw", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t4_awfull_bl", 128'(bus.burst_len_write), 128'(1'b0));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
            checkAw($sformatf("t4_fill%0d", i), 64'(i) * 64'h400, 8'd15);
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_stall_a", 128'(bus.aw_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_stall_b", 128'(bus.aw_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_pop1", 128'(bus.resp_read), 128'(1'b1));
        checkOutput("t4_pop1_aw", 128'(bus.aw_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t4_refill", 64'h2000, 8'd15);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_stall_c", 128'(bus.aw_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t4_pop2", 128'(bus.resp_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkAw("t4_same_a", 64'h2400, 8'd15);
        checkOutput("t4_same_a_pop", 128'(bus.resp_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkAw("t4_same_b", 64'h2800, 8'd15);
        checkOutput("t4_same_b_pop", 128'(bus.resp_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t4_last_slot", 64'h2C00, 8'd15);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t4_stall_d", 128'(bus.aw_write), 128'(1'b0));
        drainUntilDone("t4", 1, 9, {64'h3000, 8'd7});

        // Reset after the first burst abandons the request entirely.
        $display("[TB] mid-request reset");
        applyStimulus(1'b0, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_req_read", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t5_b0", 64'h0, 8'd15);
        applyStimulus(1'b1, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("t5_rst_req_read", 128'(bus.req_read), 128'(1'b0));
        checkOutput("t5_rst_aw_write", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t5_rst_bl_write", 128'(bus.burst_len_write), 128'(1'b0));
        checkOutput("t5_rst_resp_read", 128'(bus.resp_read), 128'(1'b0));
        checkOutput("t5_rst_done_write", 128'(bus.done_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_idle_aw", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t5_idle_done", 128'(bus.done_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_idle_done2", 128'(bus.done_write), 128'(1'b0));
        applyStimulus(1'b0, 1'b1, 64'h0, 32'd40, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_again_req_read", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t5_again_b0", 64'h0, 8'd15);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t5_again_b1", 64'h400, 8'd15);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t5_again_b2", 64'h800, 8'd7);
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t5_again_no_fourth", 128'(bus.aw_write), 128'(1'b0));
        drainUntilDone("t5", 0, 3, 72'h0);

        // Back-to-back requests with the completion FIFO full for a while.
        $display("[TB] back-to-back with done backpressure");
        applyStimulus(1'b0, 1'b1, 64'h0, 32'd16, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_req_read_a", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t6_a_b0", 64'h0, 8'd15);
        checkOutput("t6_hold_issue", 128'(bus.req_read), 128'(1'b0));
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_a_no_second", 128'(bus.aw_write), 128'(1'b0));
        checkOutput("t6_hold_issue2", 128'(bus.req_read), 128'(1'b0));
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t6_pop", 128'(bus.resp_read), 128'(1'b1));
        checkOutput("t6_hold_drain", 128'(bus.req_read), 128'(1'b0));
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_drain_done", 128'(bus.done_write), 128'(1'b0));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("t6_blocked_done%0d", i), 128'(bus.done_write), 128'(1'b0));
            checkOutput($sformatf("t6_blocked_req%0d", i), 128'(bus.req_read), 128'(1'b0));
        end
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_done_a", 128'(bus.done_write), 128'(1'b1));
        checkOutput("t6_no_req_with_done", 128'(bus.req_read), 128'(1'b0));
        applyStimulus(1'b0, 1'b1, 64'h2000, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t6_req_read_b", 128'(bus.req_read), 128'(1'b1));
        applyStimulus(1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkAw("t6_b_b0", 64'h2000, 8'd0);
        drainUntilDone("t6", 0, 1, 72'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
